// File: rtl/nettlp_cmd_rx_if.sv
// Receive-side stream from the 10G MAC into the NetTLP command parser.
interface nettlp_cmd_rx_if;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/nettlp_cmd_rx.sv
// NetTLP adapter-command ingress parser: validates Ethernet/IPv4/UDP headers on the
// 64-bit MAC stream and writes one command entry per good frame into the command FIFO.
module nettlp_cmd_rx #(
  parameter int CHECK_IP = 1,
  parameter int DWADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  nettlp_cmd_rx_if.slave      s_axis,
  input  logic [31:0]         cfg_ip,
  input  logic [15:0]         cfg_port,
  output logic                cmd_wr_en,
  input  logic                cmd_full,
  output logic [7:0]          cmd_opcode,
  output logic [DWADDR_W-1:0] cmd_dwaddr,
  output logic [31:0]         cmd_data,
  output logic [31:0]         rx_cmd_cnt,
  output logic [31:0]         rx_drop_cnt
);
  typedef enum logic [1:0] {HDR, DRAIN, PUSH} state_t;

  state_t      state;
  logic [2:0]  beat_cnt;
  logic        match;
  logic        push_ok;
  logic [7:0]  stg_opcode;
  logic [15:0] stg_dwaddr;
  logic [15:0] stg_data_hi;
  logic [15:0] stg_data_lo;
  logic [7:0]  lane [8];
  logic        beat_ok;
  logic        frame_ok;
  logic [15:0] data_lo_now;
  logic        unused_keep;

  for (genvar i = 0; i < 8; i++) begin : g_lane
    assign lane[i] = s_axis.tdata[8*i +: 8];
  end

  assign unused_keep = ^s_axis.tkeep[7:2];

  always_comb begin
    // NOTE: default assigned first so every path drives beat_ok and no latch is inferred.
    beat_ok = 1'b1;
    case (beat_cnt)
      3'd1: beat_ok = ({lane[4], lane[5]} == 16'h0800) && (lane[6] == 8'h45);
      3'd2: beat_ok = (lane[7] == 8'h11);
      3'd3: beat_ok = (CHECK_IP == 0) || ({lane[6], lane[7]} == cfg_ip[31:16]);
      3'd4: beat_ok = ((CHECK_IP == 0) || ({lane[0], lane[1]} == cfg_ip[15:0]))
                      && ({lane[4], lane[5]} == cfg_port);
      3'd6: beat_ok = !s_axis.tlast || (s_axis.tkeep[1:0] == 2'b11);
      default: beat_ok = 1'b1;
    endcase
  end

  // The tlast beat's own check and the low data half (when tlast lands on beat 6)
  // are folded in here so the verdict is complete at the tlast edge.
  assign frame_ok    = match && beat_ok && (beat_cnt >= 3'd6) && !s_axis.tuser;
  assign data_lo_now = (beat_cnt == 3'd6) ? {lane[0], lane[1]} : stg_data_lo;

  // FIFO full is judged in the push cycle itself, so the strobe cannot be registered.
  assign cmd_wr_en = (state == PUSH) && push_ok && !cmd_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= HDR;
      beat_cnt      <= '0;
      match         <= 1'b1;
      push_ok       <= 1'b0;
      s_axis.tready <= 1'b0;
      stg_opcode    <= '0;
      stg_dwaddr    <= '0;
      stg_data_hi   <= '0;
      stg_data_lo   <= '0;
      cmd_opcode    <= '0;
      cmd_dwaddr    <= '0;
      cmd_data      <= '0;
      rx_cmd_cnt    <= '0;
      rx_drop_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      s_axis.tready <= 1'b1;

      if (state == PUSH) begin
        if (push_ok && !cmd_full) rx_cmd_cnt  <= rx_cmd_cnt + 32'd1;
        else                      rx_drop_cnt <= rx_drop_cnt + 32'd1;
        state <= HDR;
      end

      // A beat arriving during PUSH is beat 0 of the next frame; it overrides the state.
      if (s_axis.tvalid) begin
        if (s_axis.tlast) begin
          state    <= PUSH;
          beat_cnt <= '0;
          match    <= 1'b1;
          push_ok  <= frame_ok;
          if (frame_ok) begin
            cmd_opcode <= stg_opcode;
            cmd_dwaddr <= stg_dwaddr[DWADDR_W-1:0];
            cmd_data   <= {stg_data_hi, data_lo_now};
          end
        end else begin
          match <= match && beat_ok;
          if (beat_cnt != 3'd7) beat_cnt <= beat_cnt + 3'd1;
          state <= (beat_cnt >= 3'd6) ? DRAIN : HDR;
          if (beat_cnt == 3'd5) begin
            stg_opcode  <= lane[2];
            stg_dwaddr  <= {lane[4], lane[5]};
            stg_data_hi <= {lane[6], lane[7]};
          end
          if (beat_cnt == 3'd6) stg_data_lo <= {lane[0], lane[1]};
        end
      end
    end
  end
endmodule

// File: tb/tb_nettlp_cmd_rx.sv
// Scoreboard bench for nettlp_cmd_rx: frames are judged by a byte-level model of the
// header rules, expected pushes are queued, and a monitor checks every cycle's strobe.
module tb_nettlp_cmd_rx;
  localparam int CHECK_IP = 1;
  localparam int DWADDR_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_ip;
  logic [15:0] cfg_port;
  logic        cmd_wr_en;
  logic        cmd_full;
  logic [7:0]  cmd_opcode;
  logic [15:0] cmd_dwaddr;
  logic [31:0] cmd_data;
  logic [31:0] rx_cmd_cnt;
  logic [31:0] rx_drop_cnt;

  nettlp_cmd_rx_if s_axis ();

  nettlp_cmd_rx #(.CHECK_IP(CHECK_IP), .DWADDR_W(DWADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_axis      (s_axis),
    .cfg_ip      (cfg_ip),
    .cfg_port    (cfg_port),
    .cmd_wr_en   (cmd_wr_en),
    .cmd_full    (cmd_full),
    .cmd_opcode  (cmd_opcode),
    .cmd_dwaddr  (cmd_dwaddr),
    .cmd_data    (cmd_data),
    .rx_cmd_cnt  (rx_cmd_cnt),
    .rx_drop_cnt (rx_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] dw;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] exp_cmd = '0;
  logic [31:0] exp_drop = '0;
  logic [7:0]  fb [0:95];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: strobe must appear exactly when an expected push is due, with its fields.
  exp_t mon_e;
  logic mon_exp;
  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) void'(sb.pop_front());
      mon_exp = (sb.size() > 0) && (sb[0].cyc == cyc);
      check("cmd_wr_en", 64'(cmd_wr_en), 64'(mon_exp));
      if (mon_exp && cmd_wr_en) begin
        mon_e = sb.pop_front();
        check("cmd_opcode", 64'(cmd_opcode), 64'(mon_e.op));
        check("cmd_dwaddr", 64'(cmd_dwaddr), 64'(mon_e.dw));
        check("cmd_data",   64'(cmd_data),   64'(mon_e.data));
      end
    end
  end

  function automatic logic [63:0] beat(input int k);
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[8*i +: 8] = fb[8*k + i];
    return d;
  endfunction

  task automatic build_good(input logic [31:0] ip, input logic [15:0] port, input logic [7:0] op,
                            input logic [15:0] dw, input logic [31:0] data, input int nb);
    for (int i = 0; i < 8*nb; i++) fb[i] = 8'($urandom);
    fb[12] = 8'h08; fb[13] = 8'h00; fb[14] = 8'h45; fb[23] = 8'h11;
    fb[30] = ip[31:24]; fb[31] = ip[23:16]; fb[32] = ip[15:8]; fb[33] = ip[7:0];
    fb[36] = port[15:8]; fb[37] = port[7:0];
    fb[42] = op; fb[44] = dw[15:8]; fb[45] = dw[7:0];
    fb[46] = data[31:24]; fb[47] = data[23:16]; fb[48] = data[15:8]; fb[49] = data[7:0];
  endtask

  // Reference: a frame is a command iff all 50 command bytes arrived, the header bytes
  // carry IPv4/UDP to this adapter, and the MAC reported no error.
  function automatic bit model_good(input int nb, input logic [7:0] keep, input logic user);
    if (nb < 7 || user) return 1'b0;
    if (nb == 7 && keep[1:0] != 2'b11) return 1'b0;
    if ({fb[12], fb[13]} != 16'h0800 || fb[14] != 8'h45 || fb[23] != 8'h11) return 1'b0;
    if (CHECK_IP != 0 && {fb[30], fb[31], fb[32], fb[33]} != cfg_ip) return 1'b0;
    if ({fb[36], fb[37]} != cfg_port) return 1'b0;
    return 1'b1;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_axis.tvalid = 1'b0;
      s_axis.tlast  = 1'b0;
    end
  endtask

  task automatic send_frame(input int nb, input logic [7:0] keep_last, input logic user,
                            input logic full, input bit gaps);
    bit   good;
    exp_t e;
    good = model_good(nb, keep_last, user);
    for (int k = 0; k < nb; k++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) idle(1);
      @(negedge clk);
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = beat(k);
      s_axis.tlast  = (k == nb - 1);
      s_axis.tkeep  = (k == nb - 1) ? keep_last : 8'($urandom);
      s_axis.tuser  = (k == nb - 1) ? user : 1'($urandom);
      if (k == nb - 1) begin
        cmd_full = full;
        if (good && !full) begin
          e.op   = fb[42];
          e.dw   = {fb[44], fb[45]};
          e.data = {fb[46], fb[47], fb[48], fb[49]};
          e.cyc  = cyc + 1;
          sb.push_back(e);
          exp_cmd++;
        end else begin
          exp_drop++;
        end
      end
    end
  endtask

  task automatic check_counts(input string tag);
    idle(3);
    check({tag, "_cmd_cnt"},  64'(rx_cmd_cnt),  64'(exp_cmd));
    check({tag, "_drop_cnt"}, 64'(rx_drop_cnt), 64'(exp_drop));
  endtask

  initial begin
    int          nb, kind;
    logic [7:0]  keep;
    logic        user, full;

    rst = 1'b1;
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tkeep = '0;
    s_axis.tlast = 1'b0; s_axis.tuser = 1'b0;
    cmd_full = 1'b0;
    cfg_ip   = 32'hC0A8_0A01;
    cfg_port = 16'h3776;
    repeat (3) @(negedge clk);
    check("tready_in_reset", 64'(s_axis.tready), 64'd0);
    check("reset_cmd_cnt",   64'(rx_cmd_cnt),    64'd0);
    check("reset_drop_cnt",  64'(rx_drop_cnt),   64'd0);
    check("reset_wr_en",     64'(cmd_wr_en),     64'd0);
    check("reset_fields",    {24'd0, cmd_opcode, cmd_dwaddr, 16'd0}, 64'd0);
    check("reset_data",      64'(cmd_data),      64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("tready_after_reset", 64'(s_axis.tready), 64'd1);

    // Good read command, 8 beats.
    build_good(cfg_ip, 16'h3776, 8'h01, 16'h0005, 32'hAABB_CCDD, 8);
    send_frame(8, 8'hFF, 1'b0, 1'b0, 1'b0);
    check_counts("good");
    check("good_dwaddr_held", 64'(cmd_dwaddr), 64'h0005);
    check("good_data_held",   64'(cmd_data),   64'hAABB_CCDD);

    // Wrong port, then wrong destination IP.
    build_good(cfg_ip, 16'h3777, 8'h02, 16'h0009, 32'h1111_2222, 8);
    send_frame(8, 8'hFF, 1'b0, 1'b0, 1'b0);
    check_counts("bad_port");
    check("fields_hold_after_drop", 64'(cmd_data), 64'hAABB_CCDD);
    build_good(32'hC0A8_0A09, 16'h3776, 8'h02, 16'h0009, 32'h1111_2222, 8);
    send_frame(8, 8'hFF, 1'b0, 1'b0, 1'b0);
    check_counts("bad_ip");

    // Runt of 6 beats, MAC error, FIFO full, partial lanes on a 7-beat tlast.
    build_good(cfg_ip, cfg_port, 8'h01, 16'h0001, 32'h0102_0304, 8);
    send_frame(6, 8'hFF, 1'b0, 1'b0, 1'b0);
    check_counts("runt");
    send_frame(8, 8'hFF, 1'b1, 1'b0, 1'b0);
    check_counts("tuser");
    send_frame(8, 8'hFF, 1'b0, 1'b1, 1'b0);
    check_counts("full");
    cmd_full = 1'b0;
    send_frame(7, 8'hFD, 1'b0, 1'b0, 1'b0);
    check_counts("short_keep");

    // Back-to-back: second frame's beat 0 lands in the first frame's push cycle.
    build_good(cfg_ip, cfg_port, 8'h02, 16'h1234, 32'h1122_3344, 7);
    send_frame(7, 8'h03, 1'b0, 1'b0, 1'b0);
    build_good(cfg_ip, cfg_port, 8'h03, 16'hBEEF, 32'h5566_7788, 8);
    send_frame(8, 8'h01, 1'b0, 1'b0, 1'b0);
    check_counts("b2b");

    // Reset while beat 3 of a good frame is on the bus.
    build_good(cfg_ip, cfg_port, 8'h04, 16'h0042, 32'hCAFE_F00D, 8);
    send_frame(3, 8'hFF, 1'b0, 1'b0, 1'b0);
    exp_drop--;
    @(negedge clk);
    s_axis.tdata = beat(3); s_axis.tlast = 1'b0; s_axis.tvalid = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("midrst_tready",   64'(s_axis.tready), 64'd0);
    check("midrst_cmd_cnt",  64'(rx_cmd_cnt),    64'd0);
    check("midrst_drop_cnt", 64'(rx_drop_cnt),   64'd0);
    check("midrst_data",     64'(cmd_data),      64'd0);
    @(negedge clk);
    rst = 1'b0;
    s_axis.tvalid = 1'b0;
    sb.delete();
    exp_cmd = '0; exp_drop = '0;
    for (int i = 0; i < 32; i++) fb[i] = fb[32 + i];
    send_frame(4, 8'hFF, 1'b0, 1'b0, 1'b0);
    check_counts("midrst_remainder");
    build_good(cfg_ip, cfg_port, 8'h05, 16'h0077, 32'h0BAD_BEEF, 9);
    send_frame(9, 8'h0F, 1'b0, 1'b0, 1'b1);
    check_counts("after_midrst");

    // Randomised traffic with gaps, corruptions and occasional full FIFO.
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        cfg_ip   = $urandom;
        cfg_port = 16'($urandom);
      end
      nb   = $urandom_range(7, 10);
      keep = 8'($urandom) | 8'h03;
      user = 1'b0;
      full = ($urandom_range(0, 7) == 0);
      build_good(cfg_ip, cfg_port, 8'($urandom), 16'($urandom), $urandom, nb);
      kind = $urandom_range(0, 14);
      case (kind)
        5:  fb[$urandom_range(36, 37)] ^= 8'($urandom_range(1, 255));
        6:  fb[$urandom_range(30, 33)] ^= 8'($urandom_range(1, 255));
        7:  fb[$urandom_range(12, 14)] ^= 8'($urandom_range(1, 255));
        8:  fb[23] ^= 8'($urandom_range(1, 255));
        9:  nb = $urandom_range(2, 6);
        10: user = 1'b1;
        11: begin nb = 7; keep[1:0] = 2'($urandom_range(0, 2)); end
        default: ;
      endcase
      send_frame(nb, keep, user, full, 1'b1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    check_counts("random");
    idle(2);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
